// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle between operand fetch, alu_seq and write-back
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_acc;
  logic [4:0]       alu_cntrl;
  logic             set_flags;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             out_err;
  logic [3:0]       alu_flags;
  logic             busy;
  modport master (
    output in_valid, alu_a, alu_b, alu_acc, alu_cntrl, set_flags, out_ready,
    input  in_ready, out_valid, alu_result, out_err, alu_flags, busy
  );
  modport slave (
    input  in_valid, alu_a, alu_b, alu_acc, alu_cntrl, set_flags, out_ready,
    output in_ready, out_valid, alu_result, out_err, alu_flags, busy
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked ARM7-style ALU with internal NZCV flags and iterative shift-add MUL/MLA
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input logic      clk,
  input logic      reset,
  alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, MULT} state_t;
  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d, err_q, err_d, mla_q, mla_d, sf_q, sf_d;
  logic [WIDTH-1:0] result_q, result_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [WIDTH-1:0] prod_q, prod_d, acc_q, acc_d;
  logic [3:0]       flags_q, flags_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       op;
  logic             c_flag, carry, is_mul, illegal, is_arith, ready, accept, v;
  logic [WIDTH-1:0] a, b, x, y, alu_res, prod_step, mul_res;
  logic [WIDTH:0]   sum;
  assign op       = bus.alu_cntrl;
  assign a        = bus.alu_a;
  assign b        = bus.alu_b;
  assign c_flag   = flags_q[1];
  assign is_mul   = MUL_EN && (op == 5'd13 || op == 5'd14);
  assign illegal  = op > 5'd12 && !is_mul;
  assign is_arith = op >= 5'd2 && op <= 5'd7;
  assign ready    = state_q == IDLE && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && ready;
  // Reverse subtracts swap the adder legs so x is always the non-inverted operand
  assign x     = (op == 5'd6 || op == 5'd7) ? b : a;
  assign y     = (op == 5'd4 || op == 5'd5) ? ~b : (op == 5'd6 || op == 5'd7) ? ~a : b;
  assign carry = (op == 5'd4 || op == 5'd6) || ((op == 5'd3 || op == 5'd5 || op == 5'd7) && c_flag);
  assign sum   = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, carry};
  assign v     = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_res   = prod_step + (mla_q ? acc_q : '0);
  always_comb begin
    alu_res = '0;
    case (op)
      5'd0:                                alu_res = a;
      5'd1:                                alu_res = b;
      5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7:  alu_res = sum[WIDTH-1:0];
      5'd8:                                alu_res = a & b;
      5'd9:                                alu_res = a ^ b;
      5'd10:                               alu_res = a | b;
      5'd11:                               alu_res = a & ~b;
      5'd12:                               alu_res = ~b;
      default:                             alu_res = '0;
    endcase
  end
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    result_d    = result_q;
    err_d       = err_q;
    flags_d     = flags_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    acc_d       = acc_q;
    mla_d       = mla_q;
    sf_d        = sf_q;
    cnt_d       = cnt_q;
    if (state_q == IDLE && accept && is_mul) begin
      state_d  = MULT;
      mcand_d  = a;
      mplier_d = b;
      prod_d   = '0;
      acc_d    = bus.alu_acc;
      mla_d    = op == 5'd14;
      sf_d     = bus.set_flags;
      cnt_d    = CW'(WIDTH);
    end else if (state_q == IDLE && accept) begin
      result_d    = illegal ? '0 : alu_res;
      err_d       = illegal;
      out_valid_d = 1'b1;
      flags_d     = (bus.set_flags && !illegal) ?
                    {alu_res[WIDTH-1], alu_res == '0, is_arith ? sum[WIDTH] : flags_q[1], is_arith ? v : flags_q[0]} :
                    flags_q;
    end else if (state_q == MULT) begin
      prod_d   = prod_step;
      mplier_d = mplier_q >> 1;
      mcand_d  = mcand_q << 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d     = IDLE;
        result_d    = mul_res;
        err_d       = 1'b0;
        out_valid_d = 1'b1;
        flags_d     = sf_q ? {mul_res[WIDTH-1], mul_res == '0, flags_q[1:0]} : flags_q;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      flags_q     <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      mla_q       <= 1'b0;
      sf_q        <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      err_q       <= err_d;
      flags_q     <= flags_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      mla_q       <= mla_d;
      sf_q        <= sf_d;
      cnt_q       <= cnt_d;
    end
  end
  assign bus.in_ready   = ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.alu_result = result_q;
  assign bus.out_err    = err_q;
  assign bus.alu_flags  = flags_q;
  assign bus.busy       = state_q == MULT;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against a reference ALU model and result queue
module tb_alu_seq;
  typedef struct packed {
    logic [31:0] res;
    logic        err;
    logic [3:0]  fl;
  } exp_t;
  logic clk, reset;
  int checks = 0, errors = 0;
  exp_t q[$];
  logic [3:0] mflags;
  logic ok;
  alu_seq_if #(.WIDTH(32)) bus ();
  alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] a, b, acc, input logic s);
    exp_t e;
    logic [31:0] x, y;
    logic ci;
    logic [32:0] t;
    logic [63:0] p;
    longint sr;
    e.err = 1'b0; e.res = '0; x = a; y = b; ci = 1'b0; p = '0;
    case (op)
      5'd0:  e.res = a;
      5'd1:  e.res = b;
      5'd2:  ci = 1'b0;
      5'd3:  ci = mflags[1];
      5'd4:  begin y = ~b; ci = 1'b1; end
      5'd5:  begin y = ~b; ci = mflags[1]; end
      5'd6:  begin x = b; y = ~a; ci = 1'b1; end
      5'd7:  begin x = b; y = ~a; ci = mflags[1]; end
      5'd8:  e.res = a & b;
      5'd9:  e.res = a ^ b;
      5'd10: e.res = a | b;
      5'd11: e.res = a & ~b;
      5'd12: e.res = ~b;
      5'd13: begin p = {32'b0, a} * {32'b0, b}; e.res = p[31:0]; end
      5'd14: begin p = {32'b0, a} * {32'b0, b} + {32'b0, acc}; e.res = p[31:0]; end
      default: e.err = 1'b1;
    endcase
    t  = {1'b0, x} + {1'b0, y} + 33'(ci);
    sr = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
    if (op >= 5'd2 && op <= 5'd7) e.res = t[31:0];
    if (s && !e.err) begin
      mflags[3] = e.res[31];
      mflags[2] = e.res == 32'd0;
      if (op >= 5'd2 && op <= 5'd7) begin
        mflags[1] = t[32];
        mflags[0] = sr != longint'($signed(t[31:0]));
      end
    end
    e.fl = mflags;
    return e;
  endfunction
  task automatic issue(input logic [4:0] op, input logic [31:0] a, b, acc, input logic s);
    int n = 0;
    bus.in_valid = 1'b1; bus.alu_cntrl = op; bus.alu_a = a; bus.alu_b = b;
    bus.alu_acc = acc; bus.set_flags = s;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    chk("accept", {31'b0, bus.in_ready}, 32'd1);
    if (bus.in_ready) q.push_back(model(op, a, b, acc, s));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q.size(), 32'd0);
    @(posedge clk); #1;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_result observed %h expected none", bus.alu_result);
      end else begin
        e = q.pop_front();
        chk("sb_result", bus.alu_result, e.res);
        chk("sb_err", {31'b0, bus.out_err}, {31'b0, e.err});
        chk("sb_flags", {28'b0, bus.alu_flags}, {28'b0, e.fl});
      end
    end
  end
  initial begin
    bus.in_valid = 1'b0; bus.alu_a = '0; bus.alu_b = '0; bus.alu_acc = '0;
    bus.alu_cntrl = '0; bus.set_flags = 1'b0; bus.out_ready = 1'b1;
    reset = 1'b1; mflags = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst_flags", {28'b0, bus.alu_flags}, 32'd0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_result", bus.alu_result, 32'd0);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_err", {31'b0, bus.out_err}, 32'd0);
    @(posedge clk); #1;
    issue(5'd2, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b1);
    drain();
    chk("add_result", bus.alu_result, 32'h80000000);
    chk("add_flags", {28'b0, bus.alu_flags}, 32'b1001);
    issue(5'd4, 32'd5, 32'd5, 32'd0, 1'b1);
    issue(5'd3, 32'd1, 32'd2, 32'd0, 1'b0);
    drain();
    chk("adc_result", bus.alu_result, 32'd4);
    chk("sub_flags", {28'b0, bus.alu_flags}, 32'b0110);
    issue(5'd13, 32'h0000FFFF, 32'h00010001, 32'd0, 1'b1);
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (!bus.busy || bus.in_ready || bus.out_valid) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("mul_busy_window", {31'b0, ok}, 32'd1);
    @(negedge clk);
    chk("mul_done_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("mul_done_busy", {31'b0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    drain();
    chk("mul_result", bus.alu_result, 32'hFFFFFFFF);
    chk("mul_flags", {28'b0, bus.alu_flags}, 32'b1010);
    issue(5'd14, 32'h0000FFFF, 32'h00010001, 32'd1, 1'b1);
    drain();
    chk("mla_result", bus.alu_result, 32'd0);
    chk("mla_flags", {28'b0, bus.alu_flags}, 32'b0110);
    bus.out_ready = 1'b0;
    issue(5'd2, 32'd10, 32'd20, 32'd0, 1'b0);
    bus.in_valid = 1'b1; bus.alu_cntrl = 5'd9; bus.alu_a = 32'hF0F0; bus.alu_b = 32'h0FF0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.alu_result !== 32'd30 || bus.in_ready) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("bp_hold", {31'b0, ok}, 32'd1);
    bus.out_ready = 1'b1;
    issue(5'd9, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0);
    @(negedge clk);
    chk("bp_next_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("bp_next_result", bus.alu_result, 32'h0000FF00);
    @(posedge clk); #1;
    drain();
    issue(5'd31, 32'd5, 32'd6, 32'd0, 1'b1);
    drain();
    chk("ill_result", bus.alu_result, 32'd0);
    chk("ill_err", {31'b0, bus.out_err}, 32'd1);
    chk("ill_flags", {28'b0, bus.alu_flags}, 32'b0110);
    issue(5'd13, 32'd3, 32'd4, 32'd0, 1'b1);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    mflags = '0;
    ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.out_valid || bus.busy || !bus.in_ready) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("abort_quiet", {31'b0, ok}, 32'd1);
    chk("abort_flags", {28'b0, bus.alu_flags}, 32'd0);
    issue(5'd0, 32'h00001234, 32'd0, 32'd0, 1'b1);
    drain();
    chk("post_abort_result", bus.alu_result, 32'h00001234);
    for (int i = 0; i < 24; i++)
      issue(5'($urandom_range(0, 15)), $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
    drain();
    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
